// File: rtl/rc4_phase_ctrl.sv
// Sequencer for the RC4 key search: runs S-init, KSA shuffle and decrypt per key and owns the S-memory mux.
// Start pulses and memory_sel are registered one cycle after the state decision; the mux itself is combinational.
// No backpressure: sub-blocks handshake through start pulse / finish level; a stalled phase aborts after TIMEOUT cycles.
module rc4_phase_ctrl #(
   parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
   parameter logic [15:0] TIMEOUT = 16'd65535,
   parameter int          GUARD   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [23:0] key_start,
   output logic        init_start,
   output logic        shuf_start,
   output logic        dec_start,
   input  logic        init_finish,
   input  logic        shuf_finish,
   input  logic        dec_finish,
   input  logic        dec_valid,
   input  logic [7:0]  init_addr,
   input  logic [7:0]  shuf_addr,
   input  logic [7:0]  dec_addr,
   input  logic [7:0]  init_data,
   input  logic [7:0]  shuf_data,
   input  logic [7:0]  dec_data,
   input  logic        init_wen,
   input  logic        shuf_wen,
   input  logic        dec_wen,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_wen,
   output logic [1:0]  memory_sel,
   output logic [23:0] secret_key,
   output logic        busy,
   output logic        key_found,
   output logic        key_fail,
   output logic        timeout_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_GO, S_INIT_WAIT, S_SHUF_GO, S_SHUF_WAIT,
      S_DEC_GO, S_DEC_WAIT, S_NEXT_KEY, S_FOUND, S_FAIL
   } state_t;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_SHUF = 2'b01;
   localparam logic [1:0] SEL_DEC  = 2'b10;
   localparam logic [1:0] SEL_INIT = 2'b11;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] timer;
   logic [23:0] key_nxt;
   logic        found_nxt;
   logic        fail_nxt;
   logic        to_nxt;
   logic [1:0]  sel_nxt;
   logic        busy_nxt;
   logic        guard_ok;
   logic        timed_out;
   logic        in_wait;
   logic        last_key;

   // A finish level older than the guard window belongs to the previous run of that sub-block.
   assign guard_ok  = (timer >= 16'(GUARD));
   // Timer is 0 on the first WAIT cycle, so TIMEOUT-1 marks the last permitted WAIT cycle.
   assign timed_out = (timer == TIMEOUT - 16'd1);
   assign in_wait   = (state == S_INIT_WAIT) || (state == S_SHUF_WAIT) || (state == S_DEC_WAIT);
   assign last_key  = (secret_key == KEY_MAX) || (secret_key == 24'hFFFFFF);

   // Next-state, key and flag decisions.
   always_comb begin
      state_nxt = state;
      key_nxt   = secret_key;
      found_nxt = key_found;
      fail_nxt  = key_fail;
      to_nxt    = timeout_err;
      case (state)
         S_IDLE, S_FOUND, S_FAIL: begin
            if (go) begin
               state_nxt = S_INIT_GO;
               key_nxt   = key_start;
               found_nxt = 1'b0;
               fail_nxt  = 1'b0;
               to_nxt    = 1'b0;
            end
         end
         S_INIT_GO: state_nxt = S_INIT_WAIT;
         S_INIT_WAIT: begin
            if (init_finish && guard_ok) begin
               state_nxt = S_SHUF_GO;
            end else if (timed_out) begin
               state_nxt = S_FAIL;
               to_nxt    = 1'b1;
            end
         end
         S_SHUF_GO: state_nxt = S_SHUF_WAIT;
         S_SHUF_WAIT: begin
            if (shuf_finish && guard_ok) begin
               state_nxt = S_DEC_GO;
            end else if (timed_out) begin
               state_nxt = S_FAIL;
               to_nxt    = 1'b1;
            end
         end
         S_DEC_GO: state_nxt = S_DEC_WAIT;
         S_DEC_WAIT: begin
            if (dec_finish && guard_ok) begin
               if (dec_valid) begin
                  state_nxt = S_FOUND;
                  found_nxt = 1'b1;
               end else if (last_key) begin
                  state_nxt = S_FAIL;
                  fail_nxt  = 1'b1;
               end else begin
                  state_nxt = S_NEXT_KEY;
               end
            end else if (timed_out) begin
               state_nxt = S_FAIL;
               to_nxt    = 1'b1;
            end
         end
         S_NEXT_KEY: begin
            key_nxt   = secret_key + 24'd1;
            state_nxt = S_INIT_GO;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory owner and busy derived from the state being entered, so they register alongside it.
   always_comb begin
      sel_nxt  = SEL_NONE;
      busy_nxt = 1'b1;
      case (state_nxt)
         S_INIT_GO, S_INIT_WAIT: sel_nxt = SEL_INIT;
         S_SHUF_GO, S_SHUF_WAIT: sel_nxt = SEL_SHUF;
         S_DEC_GO,  S_DEC_WAIT:  sel_nxt = SEL_DEC;
         default:                sel_nxt = SEL_NONE;
      endcase
      if ((state_nxt == S_IDLE) || (state_nxt == S_FOUND) || (state_nxt == S_FAIL)) begin
         busy_nxt = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // WAIT-state timer: restarts at 0 on every entry, counts while the state holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= 16'd0;
      end else if (in_wait && (state_nxt == state)) begin
         timer <= timer + 16'd1;
      end else begin
         timer <= 16'd0;
      end
   end

   // Registered Moore outputs: start pulses, mux owner, key and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_start  <= 1'b0;
         shuf_start  <= 1'b0;
         dec_start   <= 1'b0;
         memory_sel  <= SEL_NONE;
         secret_key  <= 24'd0;
         busy        <= 1'b0;
         key_found   <= 1'b0;
         key_fail    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         init_start  <= (state_nxt == S_INIT_GO);
         shuf_start  <= (state_nxt == S_SHUF_GO);
         dec_start   <= (state_nxt == S_DEC_GO);
         memory_sel  <= sel_nxt;
         secret_key  <= key_nxt;
         busy        <= busy_nxt;
         key_found   <= found_nxt;
         key_fail    <= fail_nxt;
         timeout_err <= to_nxt;
      end
   end

   // S-memory port mux; with no owner the port is held quiet so nothing can write.
   always_comb begin
      mem_addr = 8'd0;
      mem_data = 8'd0;
      mem_wen  = 1'b0;
      case (memory_sel)
         SEL_SHUF: begin
            mem_addr = shuf_addr;
            mem_data = shuf_data;
            mem_wen  = shuf_wen;
         end
         SEL_DEC: begin
            mem_addr = dec_addr;
            mem_data = dec_data;
            mem_wen  = dec_wen;
         end
         SEL_INIT: begin
            mem_addr = init_addr;
            mem_data = init_data;
            mem_wen  = init_wen;
         end
         default: begin
            mem_addr = 8'd0;
            mem_data = 8'd0;
            mem_wen  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: emulated sub-blocks, randomized side inputs, per-cycle reference model.
// Model tracks (active, phase, age-in-phase, key, flags); outputs are derived from that each negedge.
// Scenario-level literal checks pin pulse counts, key values, guard and timeout timing.
module tb_rc4_phase_ctrl;
   localparam logic [23:0] KMAX = 24'h000005;
   localparam logic [15:0] TMO  = 16'd100;
   localparam int          GRD  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        go = 1'b0;
   logic [23:0] key_start = 24'd0;
   logic        init_finish = 1'b0, shuf_finish = 1'b0, dec_finish = 1'b0, dec_valid = 1'b0;
   logic [7:0]  init_addr = 8'd0, shuf_addr = 8'd0, dec_addr = 8'd0;
   logic [7:0]  init_data = 8'd0, shuf_data = 8'd0, dec_data = 8'd0;
   logic        init_wen = 1'b0, shuf_wen = 1'b0, dec_wen = 1'b0;
   logic        init_start, shuf_start, dec_start;
   logic [7:0]  mem_addr, mem_data;
   logic        mem_wen;
   logic [1:0]  memory_sel;
   logic [23:0] secret_key;
   logic        busy, key_found, key_fail, timeout_err;

   always #5 clk = ~clk;

   rc4_phase_ctrl #(.KEY_MAX(KMAX), .TIMEOUT(TMO), .GUARD(GRD)) dut (
      .clk(clk), .reset(rst), .go(go), .key_start(key_start),
      .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
      .init_finish(init_finish), .shuf_finish(shuf_finish), .dec_finish(dec_finish),
      .dec_valid(dec_valid),
      .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
      .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
      .init_wen(init_wen), .shuf_wen(shuf_wen), .dec_wen(dec_wen),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wen(mem_wen),
      .memory_sel(memory_sel), .secret_key(secret_key), .busy(busy),
      .key_found(key_found), .key_fail(key_fail), .timeout_err(timeout_err)
   );

   // ---------------- reference model ----------------
   // ph: 1 init, 2 shuffle, 3 decrypt, 4 key increment. age 0 is the start-pulse cycle,
   // age k>=1 is the k-th cycle spent waiting for that phase's finish.
   typedef struct packed {
      logic        act;
      logic [2:0]  ph;
      logic [16:0] age;
      logic [23:0] key;
      logic        fnd;
      logic        fl;
      logic        to;
   } mst_t;

   mst_t m = '0;

   function automatic mst_t model_step(mst_t s);
      mst_t n;
      logic fin;
      n = s;
      if (!s.act) begin
         if (go) begin
            n.act = 1'b1; n.ph = 3'd1; n.age = 17'd0; n.key = key_start;
            n.fnd = 1'b0; n.fl = 1'b0; n.to = 1'b0;
         end
      end else if (s.ph == 3'd4) begin
         n.key = s.key + 24'd1; n.ph = 3'd1; n.age = 17'd0;
      end else if (s.age == 17'd0) begin
         n.age = 17'd1;
      end else begin
         fin = (s.ph == 3'd1) ? init_finish : (s.ph == 3'd2) ? shuf_finish : dec_finish;
         if (fin && (s.age > 17'(GRD))) begin
            if (s.ph < 3'd3) begin
               n.ph = s.ph + 3'd1; n.age = 17'd0;
            end else if (dec_valid) begin
               n.act = 1'b0; n.fnd = 1'b1;
            end else if ((s.key == KMAX) || (s.key == 24'hFFFFFF)) begin
               n.act = 1'b0; n.fl = 1'b1;
            end else begin
               n.ph = 3'd4; n.age = 17'd0;
            end
         end else if (s.age == 17'(TMO)) begin
            n.act = 1'b0; n.to = 1'b1;
         end else begin
            n.age = s.age + 17'd1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= model_step(m);
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         if (bad <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic compare_all();
      logic [1:0] es;
      logic [7:0] ea, ed;
      logic       ew, g;
      es = 2'b00;
      if (m.act) begin
         case (m.ph)
            3'd1:    es = 2'b11;
            3'd2:    es = 2'b01;
            3'd3:    es = 2'b10;
            default: es = 2'b00;
         endcase
      end
      ea = 8'd0; ed = 8'd0; ew = 1'b0;
      if (es == 2'b11) begin ea = init_addr; ed = init_data; ew = init_wen; end
      if (es == 2'b01) begin ea = shuf_addr; ed = shuf_data; ew = shuf_wen; end
      if (es == 2'b10) begin ea = dec_addr;  ed = dec_data;  ew = dec_wen;  end
      g = m.act && (m.age == 17'd0);
      chk("busy",        32'(busy),        32'(m.act));
      chk("memory_sel",  32'(memory_sel),  32'(es));
      chk("mem_addr",    32'(mem_addr),    32'(ea));
      chk("mem_data",    32'(mem_data),    32'(ed));
      chk("mem_wen",     32'(mem_wen),     32'(ew));
      chk("secret_key",  32'(secret_key),  32'(m.key));
      chk("key_found",   32'(key_found),   32'(m.fnd));
      chk("key_fail",    32'(key_fail),    32'(m.fl));
      chk("timeout_err", 32'(timeout_err), 32'(m.to));
      chk("init_start",  32'(init_start),  32'(g && (m.ph == 3'd1)));
      chk("shuf_start",  32'(shuf_start),  32'(g && (m.ph == 3'd2)));
      chk("dec_start",   32'(dec_start),   32'(g && (m.ph == 3'd3)));
   endtask

   // ---------------- sub-block emulation and stimulus ----------------
   int          cyc = 0;
   int          n_start[3];
   int          t_start[3];
   int          t_to;
   int          st[3];
   int          dl[3];
   int          cfg_dly[3];
   int          cfg_stale[3];
   logic [2:0]  fin_r = 3'b000;
   logic        rnd_mode = 1'b0;
   logic        use_tgt = 1'b0;
   logic        noise_ok = 1'b1;
   logic [23:0] tgt = 24'd0;

   // One clock: record this cycle's outputs, cross the edge, then drive the next cycle's inputs.
   task automatic step();
      logic [2:0] s;
      s = {dec_start, shuf_start, init_start};
      for (int b = 0; b < 3; b++) begin
         if (s[b]) begin n_start[b]++; t_start[b] = cyc; end
      end
      if (timeout_err && (t_to < 0)) t_to = cyc;
      @(posedge clk);
      #1;
      cyc++;
      for (int b = 0; b < 3; b++) begin
         if (s[b]) begin
            st[b] = rnd_mode ? int'($urandom_range(0, 3))  : cfg_stale[b];
            dl[b] = rnd_mode ? int'($urandom_range(0, 20)) : cfg_dly[b];
         end
         if (st[b] > 0) begin
            st[b]--;
         end else if (dl[b] > 0) begin
            fin_r[b] = 1'b0;
            dl[b]--;
         end else begin
            fin_r[b] = 1'b1;
         end
      end
      init_finish = fin_r[0];
      shuf_finish = fin_r[1];
      dec_finish  = fin_r[2];
      if (dec_finish) dec_valid = use_tgt && (m.key == tgt);
      else            dec_valid = noise_ok && $urandom_range(0, 1) == 1;
      go = busy && ($urandom_range(0, 7) == 0);
      if (busy) key_start = 24'($urandom);
      init_addr = 8'($urandom); shuf_addr = 8'($urandom); dec_addr = 8'($urandom);
      init_data = 8'($urandom); shuf_data = 8'($urandom); dec_data = 8'($urandom);
      init_wen  = $urandom_range(0, 1) == 1;
      shuf_wen  = $urandom_range(0, 1) == 1;
      dec_wen   = $urandom_range(0, 1) == 1;
   endtask

   task automatic clear_counts();
      for (int b = 0; b < 3; b++) begin n_start[b] = 0; t_start[b] = -1; end
      t_to = -1;
   endtask

   task automatic start_search(input logic [23:0] k);
      key_start = k;
      go = 1'b1;
      step();
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      while (busy && (n < budget)) begin step(); n++; end
      chk(nm, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      fork
         forever begin
            @(negedge clk);
            compare_all();
         end
      join_none
      for (int b = 0; b < 3; b++) begin st[b] = 0; dl[b] = 0; cfg_dly[b] = 3; cfg_stale[b] = 0; end
      clear_counts();
      rst = 1'b1;
      repeat (3) step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sel",  32'(memory_sel), 32'd0);
      chk("rst_key",  32'(secret_key), 32'd0);
      chk("rst_wen",  32'(mem_wen), 32'd0);
      chk("rst_init_start", 32'(init_start), 32'd0);
      rst = 1'b0;
      step();

      // Single key success, long sub-block latency, go pulsed during INIT_WAIT.
      rnd_mode = 1'b0; use_tgt = 1'b1; tgt = 24'h000100; noise_ok = 1'b1;
      for (int b = 0; b < 3; b++) cfg_dly[b] = 90;
      clear_counts();
      start_search(24'h000100);
      step(); step();
      go = 1'b1;
      step();
      wait_idle(2000, "A_idle");
      chk("A_n_init", 32'(n_start[0]), 32'd1);
      chk("A_n_shuf", 32'(n_start[1]), 32'd1);
      chk("A_n_dec",  32'(n_start[2]), 32'd1);
      chk("A_order",  32'((t_start[0] < t_start[1]) && (t_start[1] < t_start[2])), 32'd1);
      chk("A_found",  32'(key_found), 32'd1);
      chk("A_key",    32'(secret_key), 32'h000100);
      chk("A_sel",    32'(memory_sel), 32'd0);

      // Key search with random latencies and stale finish levels.
      rnd_mode = 1'b1; tgt = 24'd3;
      clear_counts();
      start_search(24'd0);
      wait_idle(3000, "B_idle");
      chk("B_n_dec", 32'(n_start[2]), 32'd4);
      chk("B_found", 32'(key_found), 32'd1);
      chk("B_key",   32'(secret_key), 32'd3);

      // Exhaustion at KEY_MAX.
      use_tgt = 1'b0; noise_ok = 1'b0;
      clear_counts();
      start_search(24'd4);
      wait_idle(3000, "C_idle");
      chk("C_n_dec", 32'(n_start[2]), 32'd2);
      chk("C_fail",  32'(key_fail), 32'd1);
      chk("C_found", 32'(key_found), 32'd0);
      chk("C_key",   32'(secret_key), 32'd5);
      repeat (20) step();
      chk("C_no_more_pulses", 32'(n_start[0] + n_start[1] + n_start[2]), 32'd6);

      // Shuffle never finishes: abort exactly TIMEOUT cycles into SHUF_WAIT.
      rnd_mode = 1'b0; noise_ok = 1'b1;
      cfg_dly[0] = 5; cfg_dly[1] = 1000; cfg_dly[2] = 5;
      clear_counts();
      start_search(24'd1);
      wait_idle(2000, "D_idle");
      step();
      chk("D_timeout", 32'(timeout_err), 32'd1);
      chk("D_sel",     32'(memory_sel), 32'd0);
      chk("D_to_cycles", 32'(t_to - t_start[1]), 32'd101);
      dl[1] = 0;

      // init_finish already high before go: accepted only once the guard has elapsed.
      use_tgt = 1'b1; tgt = 24'd2;
      cfg_stale[0] = 5; cfg_dly[0] = 0; cfg_dly[1] = 3; cfg_dly[2] = 3;
      fin_r[0] = 1'b1; init_finish = 1'b1; st[0] = 0; dl[0] = 0;
      clear_counts();
      start_search(24'd2);
      wait_idle(2000, "E_idle");
      chk("E_guard_gap", 32'(t_start[1] - t_start[0]), 32'd4);
      chk("E_found", 32'(key_found), 32'd1);
      cfg_stale[0] = 0;

      // Mux isolation during the shuffle phase.
      cfg_dly[0] = 3; cfg_dly[1] = 40; cfg_dly[2] = 3; tgt = 24'd1;
      clear_counts();
      start_search(24'd1);
      n = 0;
      while ((memory_sel != 2'b01) && (n < 200)) begin step(); n++; end
      repeat (3) step();
      init_wen = 1'b1; dec_wen = 1'b1; shuf_wen = 1'b0;
      #1;
      chk("F_sel",     32'(memory_sel), 32'd1);
      chk("F_wen_off", 32'(mem_wen), 32'd0);
      shuf_wen = 1'b1; shuf_addr = 8'hFC;
      #1;
      chk("F_wen_on",  32'(mem_wen), 32'd1);
      chk("F_addr",    32'(mem_addr), 32'h0FC);
      wait_idle(2000, "F_idle");

      // Reset in the middle of DEC_WAIT, then a clean restart.
      cfg_dly[1] = 3; cfg_dly[2] = 30; tgt = 24'd9;
      clear_counts();
      start_search(24'd4);
      n = 0;
      while ((n_start[2] == 0) && (n < 500)) begin step(); n++; end
      repeat (3) step();
      rst = 1'b1;
      #1;
      chk("G_busy", 32'(busy), 32'd0);
      chk("G_sel",  32'(memory_sel), 32'd0);
      chk("G_key",  32'(secret_key), 32'd0);
      chk("G_dec_start", 32'(dec_start), 32'd0);
      chk("G_wen",  32'(mem_wen), 32'd0);
      repeat (2) step();
      rst = 1'b0;
      step();
      tgt = 24'd2;
      clear_counts();
      start_search(24'd2);
      wait_idle(2000, "G_idle");
      chk("G_found", 32'(key_found), 32'd1);
      chk("G_key2",  32'(secret_key), 32'd2);
      chk("G_n_init", 32'(n_start[0]), 32'd1);

      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit actual=expired required=finish");
      $fatal(1, "time limit");
   end
endmodule
